// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback / CDB stage.
// Entry layout, widths, source ids and the ROB-relative age helpers.
package wb_pkg;

  localparam int TAG_W   = 5;
  localparam int PD_W    = 7;
  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 3;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_B   = 2'd1,
    SRC_MEM = 2'd2
  } src_e;

  typedef struct packed {
    logic [TAG_W-1:0]  rob_tag;
    logic [PD_W-1:0]   pd;
    logic              we;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [TAG_W-1:0] age(
    input logic [TAG_W-1:0] t,
    input logic [TAG_W-1:0] head
  );
    return t - head;
  endfunction

  // True when tag t is younger than the mispredicted branch ftag.
  function automatic logic killed(
    input logic [TAG_W-1:0] t,
    input logic [TAG_W-1:0] ftag,
    input logic [TAG_W-1:0] head
  );
    return age(t, head) > age(ftag, head);
  endfunction

endpackage

// File: rtl/fu_writeback_if.sv
// FU result buses, ROB/flush inputs and CDB broadcast outputs.
// master = FU cluster / ROB side, slave = writeback stage.
interface fu_writeback_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic [TAG_W-1:0]  alu_rob_tag;
  logic [PD_W-1:0]   alu_pd;
  logic              alu_we;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              b_valid;
  logic [TAG_W-1:0]  b_rob_tag;
  logic [PD_W-1:0]   b_pd;
  logic              b_we;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic              mem_valid;
  logic [TAG_W-1:0]  mem_rob_tag;
  logic [PD_W-1:0]   mem_pd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic [TAG_W-1:0]  rob_head;
  logic              mispredict;
  logic [TAG_W-1:0]  mispredict_tag;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_rob_tag;
  logic [PD_W-1:0]   cdb_pd;
  logic              cdb_we;
  logic [DATA_W-1:0] cdb_data;
  logic              overflow;

  modport master (
    output alu_valid, alu_rob_tag, alu_pd, alu_we, alu_data,
    output b_valid, b_rob_tag, b_pd, b_we, b_data,
    output mem_valid, mem_rob_tag, mem_pd, mem_we, mem_data,
    output rob_head, mispredict, mispredict_tag,
    input  alu_ready, b_ready, mem_ready,
    input  cdb_valid, cdb_rob_tag, cdb_pd, cdb_we, cdb_data,
    input  overflow
  );

  modport slave (
    input  alu_valid, alu_rob_tag, alu_pd, alu_we, alu_data,
    input  b_valid, b_rob_tag, b_pd, b_we, b_data,
    input  mem_valid, mem_rob_tag, mem_pd, mem_we, mem_data,
    input  rob_head, mispredict, mispredict_tag,
    output alu_ready, b_ready, mem_ready,
    output cdb_valid, cdb_rob_tag, cdb_pd, cdb_we, cdb_data,
    output overflow
  );

endinterface

// File: rtl/wb_fifo.sv
// Per-source result FIFO with age-based flush and compaction.
// Slot 0 is always the head; survivors are packed toward it.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  wb_entry_t        i_ent,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [TAG_W-1:0] i_ftag,
  input  logic [TAG_W-1:0] i_rob_head,
  output wb_entry_t        o_head,
  output logic             o_empty,
  output logic             o_ready,
  output logic             o_ovf
);

  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;

  wb_entry_t        w_mem [DEPTH];
  logic [DEPTH-1:0] w_vld;
  logic             w_full;
  logic             w_acc;
  int               w_n;

  assign w_full  = &r_vld;
  assign o_ready = !w_full;
  assign o_ovf   = i_push && w_full;
  assign o_empty = !r_vld[0];
  assign o_head  = r_mem[0];

  // Drop popped/flushed entries, pack survivors, then append the push.
  always_comb begin
    w_mem = r_mem;
    w_vld = '0;
    w_n   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && !(i == 0 && i_pop) &&
          !(i_flush && killed(r_mem[i].rob_tag, i_ftag, i_rob_head))) begin
        w_mem[w_n] = r_mem[i];
        w_n = w_n + 1;
      end
    end
    w_acc = i_push && !w_full &&
            !(i_flush && killed(i_ent.rob_tag, i_ftag, i_rob_head));
    if (w_acc) begin
      w_mem[w_n] = i_ent;
      w_n = w_n + 1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_vld[i] = (i < w_n);
    end
  end

  // Storage and per-entry valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_vld <= w_vld;
      r_mem <= w_mem;
    end
  end

endmodule

// File: rtl/fu_writeback.sv
// Writeback stage: per-FU buffers, oldest-first arbiter, CDB register.
// Flushed heads never win; the CDB register only loads survivors.
module fu_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  fu_writeback_if.slave bus
);

  logic             w_push [NUM_SRC];
  wb_entry_t        w_in   [NUM_SRC];
  wb_entry_t        w_head [NUM_SRC];
  logic             w_empty[NUM_SRC];
  logic             w_rdy  [NUM_SRC];
  logic             w_ovf  [NUM_SRC];
  logic             w_pop  [NUM_SRC];
  logic             w_live [NUM_SRC];
  logic [TAG_W-1:0] w_age  [NUM_SRC];

  logic             w_win_v;
  src_e             w_win;
  logic [TAG_W-1:0] w_best;

  logic             r_cdb_v;
  wb_entry_t        r_cdb;
  logic             r_ovf;

  assign w_push[SRC_ALU] = bus.alu_valid;
  assign w_push[SRC_B]   = bus.b_valid;
  assign w_push[SRC_MEM] = bus.mem_valid;

  assign w_in[SRC_ALU] = '{rob_tag: bus.alu_rob_tag, pd: bus.alu_pd,
                           we: bus.alu_we, data: bus.alu_data};
  assign w_in[SRC_B]   = '{rob_tag: bus.b_rob_tag, pd: bus.b_pd,
                           we: bus.b_we, data: bus.b_data};
  assign w_in[SRC_MEM] = '{rob_tag: bus.mem_rob_tag, pd: bus.mem_pd,
                           we: bus.mem_we, data: bus.mem_data};

  assign bus.alu_ready = w_rdy[SRC_ALU];
  assign bus.b_ready   = w_rdy[SRC_B];
  assign bus.mem_ready = w_rdy[SRC_MEM];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push[g]),
      .i_ent      (w_in[g]),
      .i_pop      (w_pop[g]),
      .i_flush    (bus.mispredict),
      .i_ftag     (bus.mispredict_tag),
      .i_rob_head (bus.rob_head),
      .o_head     (w_head[g]),
      .o_empty    (w_empty[g]),
      .o_ready    (w_rdy[g]),
      .o_ovf      (w_ovf[g])
    );

    assign w_age[g]  = age(w_head[g].rob_tag, bus.rob_head);
    assign w_live[g] = !w_empty[g] && !(bus.mispredict &&
                       killed(w_head[g].rob_tag, bus.mispredict_tag,
                              bus.rob_head));
    assign w_pop[g]  = w_win_v && (w_win == src_e'(g));
  end

  // Oldest surviving head wins; ties resolve b, then mem, then alu.
  always_comb begin
    w_win_v = 1'b0;
    w_win   = SRC_B;
    w_best  = '0;
    if (w_live[SRC_B]) begin
      w_win_v = 1'b1;
      w_win   = SRC_B;
      w_best  = w_age[SRC_B];
    end
    if (w_live[SRC_MEM] && (!w_win_v || w_age[SRC_MEM] < w_best)) begin
      w_win_v = 1'b1;
      w_win   = SRC_MEM;
      w_best  = w_age[SRC_MEM];
    end
    if (w_live[SRC_ALU] && (!w_win_v || w_age[SRC_ALU] < w_best)) begin
      w_win_v = 1'b1;
      w_win   = SRC_ALU;
      w_best  = w_age[SRC_ALU];
    end
  end

  // CDB broadcast register and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cdb_v <= 1'b0;
      r_cdb   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_cdb_v <= w_win_v;
      if (w_win_v) begin
        r_cdb <= w_head[w_win];
      end
      if (w_ovf[SRC_ALU] || w_ovf[SRC_B] || w_ovf[SRC_MEM]) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.cdb_valid   = r_cdb_v;
  assign bus.cdb_rob_tag = r_cdb.rob_tag;
  assign bus.cdb_pd      = r_cdb.pd;
  assign bus.cdb_we      = r_cdb.we;
  assign bus.cdb_data    = r_cdb.data;
  assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_fu_writeback.sv
// Directed bench for fu_writeback.
// Hand-computed expectations for ordering, flush, overflow, reset.
module tb_fu_writeback;
  import wb_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;

  fu_writeback_if bus ();

  fu_writeback #(.DEPTH(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid      = 1'b0;
    bus.b_valid        = 1'b0;
    bus.mem_valid      = 1'b0;
    bus.mispredict     = 1'b0;
    bus.mispredict_tag = '0;
  endtask

  task automatic p_alu(input logic [4:0] t);
    bus.alu_valid   = 1'b1;
    bus.alu_rob_tag = t;
    bus.alu_pd      = 7'(t) + 7'd40;
    bus.alu_we      = 1'b1;
    bus.alu_data    = 32'h100 + 32'(t);
  endtask

  task automatic p_b(input logic [4:0] t);
    bus.b_valid   = 1'b1;
    bus.b_rob_tag = t;
    bus.b_pd      = 7'(t) + 7'd40;
    bus.b_we      = 1'b0;
    bus.b_data    = 32'h200 + 32'(t);
  endtask

  task automatic p_mem(input logic [4:0] t);
    bus.mem_valid   = 1'b1;
    bus.mem_rob_tag = t;
    bus.mem_pd      = 7'(t) + 7'd40;
    bus.mem_we      = 1'b1;
    bus.mem_data    = 32'h300 + 32'(t);
  endtask

  task automatic cdb_is(input string tag, input logic [4:0] t);
    chk({tag, "_v"}, 32'(bus.cdb_valid), 32'd1);
    chk({tag, "_tag"}, 32'(bus.cdb_rob_tag), 32'(t));
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.rob_head    = '0;
    bus.alu_rob_tag = '0; bus.alu_pd = '0;
    bus.alu_we      = 1'b0; bus.alu_data = '0;
    bus.b_rob_tag   = '0; bus.b_pd = '0;
    bus.b_we        = 1'b0; bus.b_data = '0;
    bus.mem_rob_tag = '0; bus.mem_pd = '0;
    bus.mem_we      = 1'b0; bus.mem_data = '0;
    idle();
    tick();
    tick();
    reset = 1'b1;

    chk("rst_v", 32'(bus.cdb_valid), 32'd0);
    chk("rst_tag", 32'(bus.cdb_rob_tag), 32'd0);
    chk("rst_pd", 32'(bus.cdb_pd), 32'd0);
    chk("rst_we", 32'(bus.cdb_we), 32'd0);
    chk("rst_data", bus.cdb_data, 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_rdy", {29'd0, bus.alu_ready, bus.b_ready, bus.mem_ready},
        32'd7);

    // single ALU result, two-edge latency
    bus.alu_valid   = 1'b1;
    bus.alu_rob_tag = 5'd3;
    bus.alu_pd      = 7'd10;
    bus.alu_we      = 1'b1;
    bus.alu_data    = 32'hDEAD_BEEF;
    tick();
    idle();
    chk("lat_early", 32'(bus.cdb_valid), 32'd0);
    chk("lat_rdy", {29'd0, bus.alu_ready, bus.b_ready, bus.mem_ready},
        32'd7);
    tick();
    cdb_is("lat", 5'd3);
    chk("lat_pd", 32'(bus.cdb_pd), 32'd10);
    chk("lat_we", 32'(bus.cdb_we), 32'd1);
    chk("lat_data", bus.cdb_data, 32'hDEAD_BEEF);
    tick();
    chk("lat_once", 32'(bus.cdb_valid), 32'd0);

    // wrap-around age ordering
    bus.rob_head = 5'd30;
    p_alu(5'd1);
    p_mem(5'd31);
    p_b(5'd0);
    tick();
    idle();
    tick();
    cdb_is("wrap0", 5'd31);
    chk("wrap0_data", bus.cdb_data, 32'h31F);
    tick();
    cdb_is("wrap1", 5'd0);
    chk("wrap1_we", 32'(bus.cdb_we), 32'd0);
    tick();
    cdb_is("wrap2", 5'd1);
    tick();
    chk("wrap_end", 32'(bus.cdb_valid), 32'd0);

    // flush of buffered younger entries
    bus.rob_head = 5'd0;
    p_alu(5'd5);
    p_mem(5'd6);
    tick();
    idle();
    p_alu(5'd7);
    tick();
    idle();
    cdb_is("fl_keep", 5'd5);
    bus.mispredict     = 1'b1;
    bus.mispredict_tag = 5'd5;
    tick();
    idle();
    chk("fl_none0", 32'(bus.cdb_valid), 32'd0);
    tick();
    chk("fl_none1", 32'(bus.cdb_valid), 32'd0);
    tick();
    chk("fl_none2", 32'(bus.cdb_valid), 32'd0);
    chk("fl_rdy", {29'd0, bus.alu_ready, bus.b_ready, bus.mem_ready},
        32'd7);

    // flush of same-edge pushes
    bus.mispredict     = 1'b1;
    bus.mispredict_tag = 5'd4;
    p_b(5'd9);
    p_alu(5'd3);
    tick();
    idle();
    chk("fp_early", 32'(bus.cdb_valid), 32'd0);
    tick();
    cdb_is("fp_keep", 5'd3);
    tick();
    chk("fp_drop", 32'(bus.cdb_valid), 32'd0);

    // mem FIFO starved by older ALU results
    p_alu(5'd1);
    p_mem(5'd20);
    tick();
    chk("of_rdy1", 32'(bus.mem_ready), 32'd1);
    p_alu(5'd2);
    p_mem(5'd21);
    tick();
    chk("of_rdy0", 32'(bus.mem_ready), 32'd0);
    chk("of_alurdy", 32'(bus.alu_ready), 32'd1);
    chk("of_pre", 32'(bus.overflow), 32'd0);
    cdb_is("of_c1", 5'd1);
    p_alu(5'd3);
    p_mem(5'd22);
    tick();
    idle();
    chk("of_set", 32'(bus.overflow), 32'd1);
    cdb_is("of_c2", 5'd2);
    tick();
    cdb_is("of_c3", 5'd3);
    tick();
    cdb_is("of_c20", 5'd20);
    chk("of_rdyback", 32'(bus.mem_ready), 32'd1);
    tick();
    cdb_is("of_c21", 5'd21);
    tick();
    chk("of_no22", 32'(bus.cdb_valid), 32'd0);
    chk("of_stick", 32'(bus.overflow), 32'd1);

    // async reset with two entries buffered
    p_alu(5'd2);
    p_mem(5'd3);
    tick();
    idle();
    p_alu(5'd4);
    tick();
    idle();
    cdb_is("ar_pre", 5'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_v", 32'(bus.cdb_valid), 32'd0);
    chk("ar_tag", 32'(bus.cdb_rob_tag), 32'd0);
    chk("ar_ovf", 32'(bus.overflow), 32'd0);
    chk("ar_rdy", {29'd0, bus.alu_ready, bus.b_ready, bus.mem_ready},
        32'd7);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_quiet", 32'(bus.cdb_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fu_writeback.md
# fu_writeback

Writeback/common-data-bus stage that sits on the result side of the functional-unit cluster. It accepts completed results from the ALU, branch and memory units, buffers them per source, and broadcasts one result per cycle (oldest ROB tag first) to the PRF, ROB and reservation stations. It applies branch-mispredict flushes to buffered results and backpressures each FU when that unit's buffer is full.

## Interface
- DEPTH, 2, entries per source FIFO (power of two, ≥2)
- DATA_W, 32, result data width
- TAG_W, 5, ROB tag width
- PD_W, 7, physical destination register index width
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- alu_valid / b_valid / mem_valid  input  1 each  result present from that FU this cycle
- alu_rob_tag / b_rob_tag / mem_rob_tag  input  TAG_W each  ROB tag of the result
- alu_pd / b_pd / mem_pd  input  PD_W each  destination physical register
- alu_we / b_we / mem_we  input  1 each  result writes the PRF (0 for stores and branches without rd)
- alu_data / b_data / mem_data  input  DATA_W each  result value
- alu_ready / b_ready / mem_ready  output  1 each  FIFO has space (count < DEPTH)
- rob_head  input  TAG_W  current ROB head, age reference
- mispredict  input  1  flush strobe
- mispredict_tag  input  TAG_W  ROB tag of mispredicted branch (kept; younger entries killed)
- cdb_valid  output  1  broadcast valid
- cdb_rob_tag  output  TAG_W  broadcast ROB tag (marks entry complete)
- cdb_pd  output  PD_W  broadcast destination register
- cdb_we  output  1  PRF write enable / wakeup qualifier
- cdb_data  output  DATA_W  broadcast value
- overflow  output  1  sticky: a push arrived while that FIFO was full

## Operation
- Push: a source's x_valid high at a rising edge enqueues {rob_tag, pd, we, data} into that source's FIFO.
- Age: age(t) = (t − rob_head) mod 2^TAG_W, unsigned TAG_W bits. A smaller age is older.
- Arbitration, once per cycle: among non-empty FIFO heads, select the smallest age. Tie order (impossible with legal tags, but defined): b > mem > alu. The winner is popped at the edge and loaded into the CDB register.
- Only heads are considered. Within a source, order is FIFO; FUs are required to complete in-order per unit.
- Flush: when mispredict = 1 at an edge, every buffered entry with age > age(mispredict_tag) is invalidated, as is any same-edge incoming push meeting that test. Invalidated entries are compacted out: count decreases and head advances past dead entries. The CDB register is not loaded with a flushed winner; cdb_valid = 0 that cycle if no surviving winner exists.
- Full: push while count == DEPTH is dropped and sets overflow (cleared only by reset). alu_ready/b_ready/mem_ready do not account for a same-cycle pop.
- Simultaneous push and pop on one FIFO: both occur and count is unchanged.

## Timing
- Reset (reset = 0, async): all FIFOs empty; cdb_valid = 0; cdb_rob_tag, cdb_pd, cdb_data = 0; cdb_we = 0; overflow = 0; all x_ready = 1.
- Latency: a result pushed at edge E is eligible in the cycle after E. At the earliest it is loaded at edge E+1, so it is visible on cdb_* after E+1 for exactly one cycle.
- Throughput: one broadcast per cycle. With all three FUs pushing every cycle, ready deasserts after DEPTH-limited fill.
- cdb_* are registered outputs; no combinational path from x_valid or mispredict to cdb_*.
- x_ready is combinational from FIFO count only.
- Reset mid-operation drops all buffered results immediately.

## Structure
- Package wb_pkg holds: typedef wb_entry_t {rob_tag, pd, we, data}, TAG_W, PD_W, DATA_W, NUM_SRC = 3, the source index enum (SRC_ALU, SRC_B, SRC_MEM), and the age() function.
- Sub-module wb_fifo, instantiated three times: a DEPTH-entry FIFO with per-entry valid, a flush-by-age input, head/count outputs and compaction.
- The top level contains the age arbiter and the CDB register.

## Test plan
- Reset, then single ALU push with tag 3, pd 10, data 0xDEAD_BEEF, we 1 → cdb_valid = 1 two cycles later with the same fields; all ready signals stay 1.
- rob_head = 30, same-cycle pushes: alu tag 1, mem tag 31, b tag 0 → broadcast order 31, 0, 1 on consecutive cycles (wrap-around age).
- rob_head = 0, buffered alu tags 5, 7 and mem tag 6; mispredict with tag 5 → only tag 5 broadcasts; tags 6 and 7 are never seen; counts return to 0.
- mispredict with tag 4 in the same edge as a b push with tag 9 (rob_head 0) → push is discarded; push with tag 3 in the same edge is kept and broadcast.
- mem_valid held high with increasing tags while older ALU results hog arbitration → mem_ready falls after DEPTH pushes; an extra push sets overflow = 1 and it stays 1 until reset.
- Assert reset asynchronously mid-cycle with 2 entries buffered → cdb_valid drops immediately; nothing broadcasts after reset release.
